ma_stage: RTL and testbench

- Memory-access pipeline stage; sits directly upstream of the write-back unit.
- Takes decoded instruction fields from the execute stage and performs load/store through a req/ack data-memory port.
- Registers the result set the write-back unit consumes: isCall, isLd, pc, ldResult, aluResult, rd, plus a write-enable qualifier.
- Stalls upstream while a memory access is outstanding.

---
 rtl/ma_stage.sv | 187 ++++++++++++++++++
 tb/tb_ma_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// Memory-access stage: issues load/store on a req/ack port and registers the write-back result set.
// Latency 1 cycle for ALU ops, >=2 cycles for memory ops; in_ready is low while an access is outstanding.
module ma_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [4:0]        in_rd,
    input  logic              in_isLd,
    input  logic              in_isSt,
    input  logic              in_isCall,
    input  logic              in_isWb,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_aluResult,
    output logic [DATA_W-1:0] out_ldResult,
    output logic [4:0]        out_rd,
    output logic              out_isLd,
    output logic              out_isCall,
    output logic              out_isWb
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] lat_pc_q, lat_pc_d;
    logic [DATA_W-1:0] lat_alu_q, lat_alu_d;
    logic [4:0]        lat_rd_q, lat_rd_d;
    logic              lat_isLd_q, lat_isLd_d;
    logic              lat_isCall_q, lat_isCall_d;
    logic              lat_isWb_q, lat_isWb_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pc_q, out_pc_d;
    logic [DATA_W-1:0] out_alu_q, out_alu_d;
    logic [DATA_W-1:0] out_ld_q, out_ld_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_isLd_q, out_isLd_d;
    logic              out_isCall_q, out_isCall_d;
    logic              out_isWb_q, out_isWb_d;
    logic              accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        state_d      = state_q;
        lat_pc_d     = lat_pc_q;
        lat_alu_d    = lat_alu_q;
        lat_rd_d     = lat_rd_q;
        lat_isLd_d   = lat_isLd_q;
        lat_isCall_d = lat_isCall_q;
        lat_isWb_d   = lat_isWb_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        out_valid_d  = 1'b0;
        out_pc_d     = out_pc_q;
        out_alu_d    = out_alu_q;
        out_ld_d     = out_ld_q;
        out_rd_d     = out_rd_q;
        out_isLd_d   = out_isLd_q;
        out_isCall_d = out_isCall_q;
        out_isWb_d   = out_isWb_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_isLd | in_isSt) begin
                        lat_pc_d     = in_pc;
                        lat_alu_d    = in_aluResult;
                        lat_rd_d     = in_rd;
                        lat_isLd_d   = in_isLd;
                        lat_isCall_d = in_isCall;
                        lat_isWb_d   = in_isWb;
                        mem_req_d    = 1'b1;
                        // Load wins when both load and store are flagged.
                        mem_we_d     = in_isSt & ~in_isLd;
                        mem_addr_d   = in_aluResult[ADDR_W-1:0];
                        mem_wdata_d  = in_op2;
                        state_d      = ACCESS;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_pc_d     = in_pc;
                        out_alu_d    = in_aluResult;
                        out_ld_d     = '0;
                        out_rd_d     = in_rd;
                        out_isLd_d   = 1'b0;
                        out_isCall_d = in_isCall;
                        out_isWb_d   = in_isWb;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    out_valid_d  = 1'b1;
                    out_pc_d     = lat_pc_q;
                    out_alu_d    = lat_alu_q;
                    out_ld_d     = lat_isLd_q ? mem_rdata : '0;
                    out_rd_d     = lat_rd_q;
                    out_isLd_d   = lat_isLd_q;
                    out_isCall_d = lat_isCall_q;
                    out_isWb_d   = lat_isWb_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_pc_q     <= '0;
            lat_alu_q    <= '0;
            lat_rd_q     <= '0;
            lat_isLd_q   <= 1'b0;
            lat_isCall_q <= 1'b0;
            lat_isWb_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_alu_q    <= '0;
            out_ld_q     <= '0;
            out_rd_q     <= '0;
            out_isLd_q   <= 1'b0;
            out_isCall_q <= 1'b0;
            out_isWb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_pc_q     <= lat_pc_d;
            lat_alu_q    <= lat_alu_d;
            lat_rd_q     <= lat_rd_d;
            lat_isLd_q   <= lat_isLd_d;
            lat_isCall_q <= lat_isCall_d;
            lat_isWb_q   <= lat_isWb_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_alu_q    <= out_alu_d;
            out_ld_q     <= out_ld_d;
            out_rd_q     <= out_rd_d;
            out_isLd_q   <= out_isLd_d;
            out_isCall_q <= out_isCall_d;
            out_isWb_q   <= out_isWb_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_aluResult = out_alu_q;
    assign out_ldResult  = out_ld_q;
    assign out_rd        = out_rd_q;
    assign out_isLd      = out_isLd_q;
    assign out_isCall    = out_isCall_q;
    // Write-back must never see a register write outside a valid cycle.
    assign out_isWb      = out_isWb_q & out_valid_q;

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: table of ALU-op vectors plus hand-written memory sequences.
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [31:0] in_pc = '0, in_aluResult = '0, in_op2 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_isLd = 1'b0, in_isSt = 1'b0, in_isCall = 1'b0, in_isWb = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc, out_aluResult, out_ldResult;
    logic [4:0]  out_rd;
    logic        out_isLd, out_isCall, out_isWb;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ma_stage #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_pc(in_pc), .in_aluResult(in_aluResult), .in_op2(in_op2), .in_rd(in_rd),
        .in_isLd(in_isLd), .in_isSt(in_isSt), .in_isCall(in_isCall), .in_isWb(in_isWb),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_pc(out_pc), .out_aluResult(out_aluResult),
        .out_ldResult(out_ldResult), .out_rd(out_rd), .out_isLd(out_isLd),
        .out_isCall(out_isCall), .out_isWb(out_isWb)
    );

    typedef struct {
        logic        vld, fl, ack;
        logic [31:0] pc, alu;
        logic [4:0]  rd;
        logic        call, wb;
        logic        e_vld;
        logic [31:0] e_pc, e_alu;
        logic [4:0]  e_rd;
        logic        e_call, e_wb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        in_valid = 1'b0; flush = 1'b0; in_isLd = 1'b0; in_isSt = 1'b0;
        in_isCall = 1'b0; in_isWb = 1'b0; mem_ack = 1'b0;
    endtask

    // Issue one memory op and ack it after 'waits' cycles of outstanding request.
    task automatic mem_op(input string tag, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic wb, input int waits);
        logic        exp_we;
        logic [31:0] exp_ld;
        exp_we = st & ~ld;
        exp_ld = ld ? rdata : 32'h0;
        in_valid = 1'b1; in_isLd = ld; in_isSt = st; in_aluResult = addr;
        in_op2 = wdata; in_rd = rd; in_isWb = wb; in_pc = 32'h100; in_isCall = 1'b0;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < waits; k++) begin
            chk({tag, ".req"}, mem_req, 1);
            chk({tag, ".we"}, mem_we, exp_we);
            chk({tag, ".addr"}, mem_addr, addr);
            chk({tag, ".wdata"}, mem_wdata, wdata);
            chk({tag, ".in_ready"}, in_ready, 0);
            chk({tag, ".out_valid_wait"}, out_valid, 0);
            if (k == waits - 1) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            cyc();
        end
        mem_ack = 1'b0; mem_rdata = 32'h0BAD_F00D;
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".ldResult"}, out_ldResult, exp_ld);
        chk({tag, ".isLd"}, out_isLd, ld);
        chk({tag, ".isWb"}, out_isWb, wb);
        chk({tag, ".alu"}, out_aluResult, addr);
        chk({tag, ".rd"}, out_rd, rd);
        chk({tag, ".req_drop"}, mem_req, 0);
        chk({tag, ".ready_back"}, in_ready, 1);
        cyc();
        chk({tag, ".pulse_end"}, out_valid, 0);
    endtask

    vec_t tbl[9];
    int   pulses;

    initial begin
        tbl[0] = '{1,0,0, 32'h00, 32'h1234, 5'd5,  0,1, 1, 32'h00, 32'h1234, 5'd5,  0,1};
        tbl[1] = '{1,0,0, 32'h04, 32'h0011, 5'd1,  0,1, 1, 32'h04, 32'h0011, 5'd1,  0,1};
        tbl[2] = '{1,0,0, 32'h08, 32'h0022, 5'd2,  0,1, 1, 32'h08, 32'h0022, 5'd2,  0,1};
        tbl[3] = '{1,0,0, 32'h0C, 32'h0033, 5'd3,  0,0, 1, 32'h0C, 32'h0033, 5'd3,  0,0};
        tbl[4] = '{1,0,0, 32'h20, 32'h0024, 5'd31, 1,1, 1, 32'h20, 32'h0024, 5'd31, 1,1};
        tbl[5] = '{0,0,0, 32'h99, 32'hFFFF, 5'd9,  0,1, 0, 32'h20, 32'h0024, 5'd31, 1,0};
        tbl[6] = '{1,1,0, 32'h44, 32'h5555, 5'd7,  0,1, 0, 32'h20, 32'h0024, 5'd31, 1,0};
        tbl[7] = '{0,0,1, 32'h00, 32'h0000, 5'd0,  0,0, 0, 32'h20, 32'h0024, 5'd31, 1,0};
        tbl[8] = '{1,0,0, 32'h48, 32'hCAFE, 5'd9,  0,1, 1, 32'h48, 32'hCAFE, 5'd9,  0,1};

        // Reset values
        #12;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_isWb", out_isWb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 9; i++) begin
            in_valid = tbl[i].vld; flush = tbl[i].fl; mem_ack = tbl[i].ack;
            in_pc = tbl[i].pc; in_aluResult = tbl[i].alu; in_rd = tbl[i].rd;
            in_isCall = tbl[i].call; in_isWb = tbl[i].wb; in_isLd = 1'b0; in_isSt = 1'b0;
            mem_rdata = 32'h7777_7777;
            cyc();
            chk($sformatf("v%0d.out_valid", i), out_valid, tbl[i].e_vld);
            chk($sformatf("v%0d.pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("v%0d.alu", i), out_aluResult, tbl[i].e_alu);
            chk($sformatf("v%0d.rd", i), out_rd, tbl[i].e_rd);
            chk($sformatf("v%0d.call", i), out_isCall, tbl[i].e_call);
            chk($sformatf("v%0d.wb", i), out_isWb, tbl[i].e_wb);
            chk($sformatf("v%0d.ld", i), out_ldResult, 0);
            chk($sformatf("v%0d.mem_req", i), mem_req, 0);
        end
        idle_in();
        cyc();

        mem_op("load", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5'd4, 1'b1, 3);
        mem_op("store", 1'b0, 1'b1, 32'h10, 32'hA5A5, 32'h0, 5'd3, 1'b0, 2);
        mem_op("ldst", 1'b1, 1'b1, 32'h60, 32'h1111, 32'h600D, 5'd6, 1'b1, 1);

        // Flush held with a second op offered while a load is in flight
        in_valid = 1'b1; in_isLd = 1'b1; in_aluResult = 32'h80; in_rd = 5'd8; in_isWb = 1'b1;
        cyc();
        flush = 1'b1; in_isLd = 1'b0; in_aluResult = 32'h9999; in_rd = 5'd12;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            mem_ack = (k == 1);
            mem_rdata = 32'h8080;
            cyc();
            if (out_valid) pulses++;
            if (out_valid) chk("flush.kept_alu", out_aluResult, 32'h80);
        end
        chk("flush.pulses", pulses, 1);
        chk("flush.ld", out_ldResult, 32'h8080);
        idle_in();
        cyc();

        // Reset in the middle of a load
        in_valid = 1'b1; in_isLd = 1'b1; in_aluResult = 32'hC0; in_pc = 32'h300;
        cyc();
        idle_in();
        cyc();
        chk("rmid.req_before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rmid.req", mem_req, 0);
        chk("rmid.out_alu", out_aluResult, 0);
        chk("rmid.out_pc", out_pc, 0);
        chk("rmid.out_ld", out_ldResult, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        cyc();
        mem_ack = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) pulses++;
            cyc();
        end
        chk("rmid.pulses", pulses, 0);
        chk("rmid.ready", in_ready, 1);
        chk("rmid.req_after", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
